// File: rtl/ins_decode_stage.sv
// Instruction-decode stage: a small FIFO of fetched {instr, pc} pairs with
// combinational decode of the head entry into MIPS R/I/J fields and targets.
module ins_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_fmt,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [XLEN-1:0] out_imm_ext,
    output logic [XLEN-1:0] out_br_target,
    output logic [XLEN-1:0] out_jaddr,
    output logic [XLEN-1:0] out_pc
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     count_q;

    logic            push, pop;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc, pc4, sext, br;
    logic [5:0]      op;
    logic [15:0]     imm16;

    assign in_ready  = count_q < (PW + 1)'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // FIFO storage, pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr_q] <= in_instr;
                pc_q[wr_ptr_q]    <= in_pc;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head_instr = instr_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
    assign op         = head_instr[31:26];
    assign imm16      = head_instr[15:0];
    assign pc4        = head_pc + XLEN'(4);
    assign sext       = XLEN'($signed(imm16));
    assign br         = pc4 + {sext[XLEN-3:0], 2'b00};

    // Decode of the head entry; everything is zero while the FIFO is empty
    always_comb begin
        out_fmt       = 2'd0;
        out_opcode    = '0;
        out_rs        = '0;
        out_rt        = '0;
        out_rd        = '0;
        out_shamt     = '0;
        out_funct     = '0;
        out_imm_ext   = '0;
        out_br_target = '0;
        out_jaddr     = '0;
        out_pc        = '0;
        if (out_valid) begin
            out_opcode = op;
            out_pc     = head_pc;
            case (op)
                6'h00: begin
                    out_fmt   = 2'd0;
                    out_rs    = head_instr[25:21];
                    out_rt    = head_instr[20:16];
                    out_rd    = head_instr[15:11];
                    out_shamt = head_instr[10:6];
                    out_funct = head_instr[5:0];
                end
                6'h02, 6'h03: begin
                    out_fmt   = 2'd2;
                    out_jaddr = {pc4[XLEN-1:28], head_instr[25:0], 2'b00};
                end
                default: begin
                    out_fmt       = 2'd1;
                    out_rs        = head_instr[25:21];
                    out_rt        = head_instr[20:16];
                    out_br_target = br;
                    case (op)
                        6'h0C, 6'h0D, 6'h0E: out_imm_ext = XLEN'(imm16);
                        6'h0F:               out_imm_ext = XLEN'({imm16, 16'h0000});
                        default:             out_imm_ext = sext;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: doc/ins_decode_stage.md
Name: ins_decode_stage

Overview:
Parametrised instruction-decode stage for the MIPS datapath. It buffers fetched instructions in a small FIFO and presents fully decoded fields for the FIFO head: format, register fields, extended immediate, branch target and jump target. A valid/ready handshake sits on both sides, and a synchronous flush clears the stage after a taken branch or jump. It sits between instruction fetch and register read.

Parameters:
XLEN, 32, width of the PC, the extended immediate and the target outputs; must be >= 32.
DEPTH, 2, number of FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage can accept; equals (count < DEPTH).
in_instr  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_instr.
flush  input  1  synchronous discard of all buffered entries.
out_valid  output  1  FIFO is non-empty; decoded outputs are valid.
out_ready  input  1  downstream consumes the head entry.
out_fmt  output  2  format code: 0 = R, 1 = I, 2 = J, 3 = unused.
out_opcode  output  6  instr[31:26].
out_rs, out_rt, out_rd, out_shamt  output  5 each  register and shift-amount fields.
out_funct  output  6  instr[5:0].
out_imm_ext  output  XLEN  extended immediate.
out_br_target  output  XLEN  branch target address.
out_jaddr  output  XLEN  jump target address.
out_pc  output  XLEN  PC of the head entry.

Behaviour:
- Storage: circular FIFO of {instr, pc}, with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any non-empty count below DEPTH.
- When full, in_ready = 0. There is no same-cycle pass-through, so a pop while full frees a slot only from the next cycle.
- Latency: an instruction accepted at edge N is visible at the head no earlier than the cycle after edge N. Order is strictly FIFO.
- Decode is combinational from the registered head entry only. Outputs are stable while out_valid && !out_ready.
- Format and field rules:
  - Opcode 0x00 is R-type: rs, rt, rd, shamt and funct are driven. imm_ext, br_target and jaddr are 0.
  - Opcode 0x02 or 0x03 is J-type: jaddr = {(pc+4)[XLEN-1:28], instr[25:0], 2'b00}. All other fields except opcode are 0.
  - Any other opcode is I-type: rs, rt and imm_ext are driven. rd, shamt, funct and jaddr are 0.
- Immediate extension (I-type only):
  - 0x0C, 0x0D, 0x0E: zero-extend.
  - 0x0F (lui): {zero-extend(imm16), 16'h0}.
  - All others: sign-extend.
- br_target (I-type only) = pc + 4 + (sign-extended imm16 << 2), mod 2^XLEN. It is computed for every I-type, including non-branches.
- When out_valid = 0, all decoded outputs and out_pc are forced to 0.
- flush: at the next edge, count, read pointer and write pointer are cleared to 0. A push or pop in the same cycle is discarded. out_valid = 0 in the following cycle.
- Reset (rst_n low, asynchronous, including mid-transfer): pointers, count and storage are cleared. out_valid = 0, in_ready = 1, and all decoded outputs are 0. The first push is accepted on the first edge after rst_n deasserts.

Test Plan:
1. Assert rst_n low mid-stream with 2 entries buffered -> immediately out_valid=0, in_ready=1, all outputs 0; after release, push 0x012A4020 -> accepted.
2. R-type 0x012A4020 at pc 0x00400000 -> fmt=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, imm_ext=0, jaddr=0, out_pc=0x00400000.
3. I-type at pc 0x00400010:
   - 0x2128FFFC -> rs=9, rt=8, imm_ext=0xFFFFFFFC, br_target=0x00400004.
   - 0x3528FFFF -> imm_ext=0x0000FFFF.
   - 0x3C081234 -> imm_ext=0x12340000.
4. J-type 0x08100004 at pc 0x00400020 -> fmt=2, jaddr=0x00400010, rs=rt=rd=0, imm_ext=0.
5. DEPTH=2, out_ready=0, push A, B, C -> in_ready=0 after B and C is held. Raise out_ready -> A, B, C emerge in order, one per cycle, with no loss or duplication.
6. With 1 entry buffered, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, and the pushed instruction never appears.
